snn_cfg_sequencer: RTL and testbench

- Front-end controller for the two-layer delayed SNN core.
- Receives a byte-serial command/config stream and holds the full configuration image: weights, packed delays, threshold, decay and refractory period.
- Sequences the core: holds it in reset while loading, then runs it with `enable` and a periodic `delay_clk` tick.
- Sits between the chip byte I/O and the SNN top; all its config outputs are quasi-static.

---
 rtl/snn_cfg_pkg.sv | 24 ++
 rtl/snn_tick_divider.sv | 40 ++++
 rtl/snn_cfg_sequencer.sv | 181 ++++++++++++++++++
 tb/tb_snn_cfg_sequencer.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/snn_cfg_pkg.sv
// Shared definitions for the SNN configuration sequencer: command codes, FSM states
// and byte offsets of the fields inside the configuration image.
package snn_cfg_pkg;

    localparam logic [7:0] CMD_LOAD = 8'h01;
    localparam logic [7:0] CMD_RUN  = 8'h02;
    localparam logic [7:0] CMD_STOP = 8'h03;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LOAD = 2'd1,
        RUN  = 2'd2
    } state_e;

    localparam int unsigned WEIGHT_BASE  = 0;
    localparam int unsigned DELAY_BASE   = 144;
    localparam int unsigned THR_IDX      = 216;
    localparam int unsigned DECAY_IDX    = 217;
    localparam int unsigned REFR_IDX     = 218;

    localparam int unsigned WEIGHT_BYTES = DELAY_BASE - WEIGHT_BASE;
    localparam int unsigned DELAY_BYTES  = THR_IDX - DELAY_BASE;

endpackage

// File: rtl/snn_tick_divider.sv
// Free-running DELAY_DIV divider for the RUN state; emits a registered one-cycle tick
// whenever the count reaches DELAY_DIV-1. Clearing restarts the count from zero.
module snn_tick_divider #(
    parameter int unsigned DELAY_DIV = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic clr,
    input  logic run,
    output logic tick
);

    localparam int unsigned DIV_W = $clog2(DELAY_DIV);
    localparam logic [DIV_W-1:0] LAST = DIV_W'(DELAY_DIV - 1);

    logic [DIV_W-1:0] div_q, div_d;
    logic             tick_q, tick_d;

    always_comb begin
        div_d = '0;
        if (run && !clr) begin
            div_d = (div_q == LAST) ? '0 : div_q + 1'b1;
        end
        // Tick tracks the registered count, so it is high exactly while div_q == LAST.
        tick_d = run && (div_d == LAST);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            div_q  <= '0;
            tick_q <= 1'b0;
        end else begin
            div_q  <= div_d;
            tick_q <= tick_d;
        end
    end

    assign tick = tick_q;

endmodule

// File: rtl/snn_cfg_sequencer.sv
// Byte-serial config loader and run sequencer for the two-layer delayed SNN core.
// Optional trailing XOR checksum byte on LOAD is enabled by defining SNN_CFG_CHECKSUM_EN.
module snn_cfg_sequencer
    import snn_cfg_pkg::*;
#(
    parameter int unsigned CFG_BYTES = 219,
    parameter int unsigned DELAY_DIV = 4,
    parameter int unsigned CNT_W     = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [7:0]                data_in,
    input  logic                      data_valid,
    output logic [WEIGHT_BYTES*8-1:0] weights,
    output logic [DELAY_BYTES*8-1:0]  delays,
    output logic [7:0]                threshold,
    output logic [7:0]                decay,
    output logic [7:0]                refractory_period,
    output logic                      net_reset,
    output logic                      enable,
    output logic                      delay_clk,
    output logic                      busy,
    output logic                      cfg_valid,
    output logic                      cfg_error
);

    localparam int unsigned      IMG_W    = CFG_BYTES * 8;
    localparam logic [CNT_W-1:0] LAST_IDX = CNT_W'(CFG_BYTES - 1);

    state_e             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [IMG_W-1:0]   img_q, img_d;
    logic               net_reset_q, net_reset_d;
    logic               enable_q, enable_d;
    logic               busy_q, busy_d;
    logic               cfg_valid_q, cfg_valid_d;
    logic               load_start;
    logic               cmd_load, cmd_run, cmd_stop;
    logic               div_clr, div_run;

`ifdef SNN_CFG_CHECKSUM_EN
    localparam logic [CNT_W-1:0] CKS_IDX = CNT_W'(CFG_BYTES);

    logic [7:0] xor_q, xor_d;
    logic       cfg_error_q, cfg_error_d;
`endif

    assign cmd_load = data_valid && (data_in == CMD_LOAD);
    assign cmd_run  = data_valid && (data_in == CMD_RUN);
    assign cmd_stop = data_valid && (data_in == CMD_STOP);

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        img_d       = img_q;
        cfg_valid_d = cfg_valid_q;
        load_start  = 1'b0;
`ifdef SNN_CFG_CHECKSUM_EN
        xor_d       = xor_q;
        cfg_error_d = cfg_error_q;
`endif

        unique case (state_q)
            IDLE: begin
                if (cmd_load) begin
                    state_d    = LOAD;
                    load_start = 1'b1;
                end else if (cmd_run && cfg_valid_q) begin
                    state_d = RUN;
                end
            end
            LOAD: begin
                // Every byte here is payload; command codes are not decoded.
                if (data_valid) begin
`ifdef SNN_CFG_CHECKSUM_EN
                    if (cnt_q == CKS_IDX) begin
                        state_d     = IDLE;
                        cfg_valid_d = (data_in == xor_q);
                        cfg_error_d = (data_in != xor_q);
                    end else begin
                        img_d[{cnt_q, 3'b000} +: 8] = data_in;
                        xor_d                       = xor_q ^ data_in;
                        cnt_d                       = cnt_q + 1'b1;
                    end
`else
                    img_d[{cnt_q, 3'b000} +: 8] = data_in;
                    cnt_d                       = cnt_q + 1'b1;
                    if (cnt_q == LAST_IDX) begin
                        state_d     = IDLE;
                        cfg_valid_d = 1'b1;
                    end
`endif
                end
            end
            RUN: begin
                // LOAD while running stops the core and goes straight to loading.
                if (cmd_load) begin
                    state_d    = LOAD;
                    load_start = 1'b1;
                end else if (cmd_stop) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        if (load_start) begin
            cnt_d       = '0;
            cfg_valid_d = 1'b0;
`ifdef SNN_CFG_CHECKSUM_EN
            xor_d       = '0;
            cfg_error_d = 1'b0;
`endif
        end

        net_reset_d = (state_d != RUN);
        enable_d    = (state_d == RUN);
        busy_d      = (state_d == LOAD);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            img_q       <= '0;
            net_reset_q <= 1'b1;
            enable_q    <= 1'b0;
            busy_q      <= 1'b0;
            cfg_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            img_q       <= img_d;
            net_reset_q <= net_reset_d;
            enable_q    <= enable_d;
            busy_q      <= busy_d;
            cfg_valid_q <= cfg_valid_d;
        end
    end

`ifdef SNN_CFG_CHECKSUM_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xor_q       <= '0;
            cfg_error_q <= 1'b0;
        end else begin
            xor_q       <= xor_d;
            cfg_error_q <= cfg_error_d;
        end
    end

    assign cfg_error = cfg_error_q;
`else
    assign cfg_error = 1'b0;
`endif

    // Divider restarts on RUN entry so the first tick lands DELAY_DIV cycles after the command.
    assign div_clr = (state_q != RUN);
    assign div_run = (state_d == RUN);

    snn_tick_divider #(
        .DELAY_DIV (DELAY_DIV)
    ) u_tick_divider (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (div_clr),
        .run   (div_run),
        .tick  (delay_clk)
    );

    assign weights           = img_q[WEIGHT_BASE*8 +: WEIGHT_BYTES*8];
    assign delays            = img_q[DELAY_BASE*8 +: DELAY_BYTES*8];
    assign threshold         = img_q[THR_IDX*8 +: 8];
    assign decay             = img_q[DECAY_IDX*8 +: 8];
    assign refractory_period = img_q[REFR_IDX*8 +: 8];
    assign net_reset         = net_reset_q;
    assign enable            = enable_q;
    assign busy              = busy_q;
    assign cfg_valid         = cfg_valid_q;

endmodule

// File: tb/tb_snn_cfg_sequencer.sv
// Scoreboard bench for snn_cfg_sequencer: stimulus queues expected status/image events,
// a negedge monitor pops one whenever the outputs change, a tick fires, or a probe is requested.
module tb_snn_cfg_sequencer;

    localparam int CFG_BYTES = 219;
    localparam int IMG_W     = CFG_BYTES * 8;

    logic              clk = 1'b0;
    logic              rst_n = 1'b0;
    logic [7:0]        data_in = 8'h00;
    logic              data_valid = 1'b0;
    logic [1151:0]     weights;
    logic [575:0]      delays;
    logic [7:0]        threshold, decay, refractory_period;
    logic              net_reset, enable, delay_clk, busy, cfg_valid, cfg_error;

    snn_cfg_sequencer #(
        .CFG_BYTES (219),
        .DELAY_DIV (4),
        .CNT_W     (8)
    ) dut (
        .clk               (clk),
        .rst_n             (rst_n),
        .data_in           (data_in),
        .data_valid        (data_valid),
        .weights           (weights),
        .delays            (delays),
        .threshold         (threshold),
        .decay             (decay),
        .refractory_period (refractory_period),
        .net_reset         (net_reset),
        .enable            (enable),
        .delay_clk         (delay_clk),
        .busy              (busy),
        .cfg_valid         (cfg_valid),
        .cfg_error         (cfg_error)
    );

    always #5 clk = ~clk;

    int unsigned cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Scoreboard: parallel queues of expected events.
    string            exp_nm_q[$];
    int unsigned      exp_cyc_q[$];
    logic [5:0]       exp_st_q[$];
    logic [IMG_W-1:0] exp_img_q[$];

    int  checks = 0;
    int  errors = 0;
    int  probe_req = 0;
    int  probe_ack = 0;
    bit  done = 1'b0;
    bit  finished = 1'b0;

    logic [IMG_W-1:0] exp_img;
    bit               exp_valid, exp_error;
    logic [7:0]       pay [CFG_BYTES];
    int unsigned      n;

    // Status vector order: net_reset, enable, busy, cfg_valid, cfg_error, delay_clk.
    function automatic logic [5:0] st(input logic nr, input logic en, input logic bs,
                                      input logic v, input logic e, input logic dc);
        return {nr, en, bs, v, e, dc};
    endfunction

    task automatic idle();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [7:0] b);
        data_in    = b;
        data_valid = 1'b1;
        @(posedge clk);
        #1;
        data_valid = 1'b0;
        data_in    = 8'h00;
    endtask

    task automatic push(input string nm, input int unsigned at, input logic [5:0] s);
        exp_nm_q.push_back(nm);
        exp_cyc_q.push_back(at);
        exp_st_q.push_back(s);
        exp_img_q.push_back(exp_img);
    endtask

    task automatic probe(input string nm, input logic [5:0] s);
        push(nm, cyc, s);
        probe_req++;
    endtask

    task automatic do_load(input string nm, input bit gaps, input int nbytes, input bit bad_cks);
        logic [7:0] x;
        x = 8'h00;
        send(8'h01);
        exp_valid = 1'b0;
        exp_error = 1'b0;
        push({nm, "_start"}, cyc, st(1, 0, 1, 0, 0, 0));
        for (int k = 0; k < nbytes; k++) begin
            if (gaps && (k % 16) == 5) begin
                idle();
                idle();
            end
            send(pay[k]);
            exp_img[k*8 +: 8] = pay[k];
            x = x ^ pay[k];
        end
        if (nbytes == CFG_BYTES) begin
`ifdef SNN_CFG_CHECKSUM_EN
            send(bad_cks ? (x ^ 8'h10) : x);
            exp_valid = !bad_cks;
            exp_error = bad_cks;
`else
            exp_valid = 1'b1;
`endif
            push({nm, "_done"}, cyc, st(1, 0, 0, exp_valid, exp_error, 0));
        end
    endtask

    // Monitor
    logic [5:0]       prev_st = 6'b100000;
    logic [5:0]       m_cur, m_st;
    logic [IMG_W-1:0] m_img, m_exp_img;
    bit               m_ev;
    string            m_nm;
    int unsigned      m_at;
    int               m_first;

    always @(negedge clk) begin
        m_cur = {net_reset, enable, busy, cfg_valid, cfg_error, delay_clk};
        m_img = {refractory_period, decay, threshold, delays, weights};
        m_ev  = (m_cur[5:1] != prev_st[5:1]) || m_cur[0] || (probe_req != probe_ack);
        probe_ack = probe_req;
        prev_st   = m_cur;
        if (m_ev) begin
            if (exp_st_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_event cyc=%0d got st=%b want no event", cyc, m_cur);
            end else begin
                m_nm      = exp_nm_q.pop_front();
                m_at      = exp_cyc_q.pop_front();
                m_st      = exp_st_q.pop_front();
                m_exp_img = exp_img_q.pop_front();
                checks++;
                if (m_at != cyc || m_st != m_cur) begin
                    errors++;
                    $display("FAIL %s status got st=%b at cyc %0d want st=%b at cyc %0d",
                             m_nm, m_cur, cyc, m_st, m_at);
                end
                checks++;
                if (m_img != m_exp_img) begin
                    m_first = -1;
                    for (int k = CFG_BYTES - 1; k >= 0; k--) begin
                        if (m_img[k*8 +: 8] != m_exp_img[k*8 +: 8]) m_first = k;
                    end
                    errors++;
                    $display("FAIL %s image byte %0d got %h want %h", m_nm, m_first,
                             m_img[m_first*8 +: 8], m_exp_img[m_first*8 +: 8]);
                end
            end
        end
        if (done && !finished) begin
            checks++;
            if (exp_st_q.size() != 0) begin
                errors++;
                $display("FAIL drain pending=%0d want 0 next=%s", exp_st_q.size(), exp_nm_q[0]);
            end
            finished = 1'b1;
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog cyc=%0d want finish", cyc);
        $fatal(1, "watchdog");
    end

    initial begin
        exp_img   = '0;
        exp_valid = 1'b0;
        exp_error = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;
        probe("reset", st(1, 0, 0, 0, 0, 0));
        idle();

        // RUN without a loaded image, STOP in IDLE and a junk byte: all ignored.
        send(8'h02);
        idle();
        probe("run_without_cfg", st(1, 0, 0, 0, 0, 0));
        send(8'h03);
        send(8'h7E);
        idle();
        probe("idle_junk", st(1, 0, 0, 0, 0, 0));

        // Byte value = index: weights[7:0]=00, delays[7:0]=90, thr D8, decay D9, refr DA.
        for (int k = 0; k < CFG_BYTES; k++) pay[k] = 8'(k);
        do_load("load_idx", 1'b0, CFG_BYTES, 1'b0);
        idle();
        probe("after_load", st(1, 0, 0, 1, 0, 0));

        // RUN: ticks 4, 8, 12 cycles after the command cycle, then STOP.
        send(8'h02);
        n = cyc;
        push("run_enter", n, st(0, 1, 0, 1, 0, 0));
        push("tick1", n + 3, st(0, 1, 0, 1, 0, 1));
        push("tick2", n + 7, st(0, 1, 0, 1, 0, 1));
        push("tick3", n + 11, st(0, 1, 0, 1, 0, 1));
        while (cyc < n + 11) idle();
        send(8'h03);
        push("stop", n + 12, st(1, 0, 0, 1, 0, 0));
        idle();
        probe("after_stop", st(1, 0, 0, 1, 0, 0));

        // LOAD issued from RUN, with valid gaps and command codes inside the payload.
        send(8'h02);
        push("rerun", cyc, st(0, 1, 0, 1, 0, 0));
        idle();
        for (int k = 0; k < CFG_BYTES; k++) pay[k] = 8'(k) ^ 8'hA5;
        pay[5] = 8'h02;
        pay[6] = 8'h03;
        pay[7] = 8'h01;
        do_load("load_gap_from_run", 1'b1, CFG_BYTES, 1'b0);
        idle();
        probe("after_gap_load", st(1, 0, 0, 1, 0, 0));

`ifdef SNN_CFG_CHECKSUM_EN
        for (int k = 0; k < CFG_BYTES; k++) pay[k] = 8'(k * 3);
        do_load("cks_good", 1'b0, CFG_BYTES, 1'b0);
        idle();
        do_load("cks_bad", 1'b0, CFG_BYTES, 1'b1);
        idle();
        send(8'h02);
        idle();
        probe("run_after_bad_cks", st(1, 0, 0, 0, 1, 0));
`endif

        // Asynchronous reset after 100 payload bytes.
        for (int k = 0; k < CFG_BYTES; k++) pay[k] = 8'(k) ^ 8'h3C;
        do_load("partial", 1'b0, 100, 1'b0);
        probe("partial_img", st(1, 0, 1, 0, 0, 0));
        idle();
        rst_n     = 1'b0;
        exp_img   = '0;
        exp_valid = 1'b0;
        exp_error = 1'b0;
        push("async_reset", cyc, st(1, 0, 0, 0, 0, 0));
        idle();
        idle();
        rst_n = 1'b1;
        idle();
        send(8'h02);
        idle();
        idle();
        probe("run_after_reset", st(1, 0, 0, 0, 0, 0));

        repeat (4) idle();
        done = 1'b1;
        wait (finished);
        #1;
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
